multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit_pkg.sv | 22 ++
 rtl/multdiv_unit_twos_negate.sv | 12 +
 rtl/multdiv_unit.sv | 130 +++++++++++++
 tb/tb_multdiv_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_unit_pkg.sv
// rtl/multdiv_unit_pkg.sv - shared constants and encodings for the multiply/divide unit
package multdiv_unit_pkg;

   localparam int WIDTH = 32;
   localparam int ITERS = WIDTH;
   localparam int CNT_W = $clog2(ITERS);

   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] NEG_ONE = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_t;

endpackage

// File: rtl/multdiv_unit_twos_negate.sv
// rtl/multdiv_unit_twos_negate.sv - conditional two's complement negate (invert plus increment)
module multdiv_unit_twos_negate
   import multdiv_unit_pkg::*;
(
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   assign y = (a ^ {WIDTH{en}}) + {{(WIDTH-1){1'b0}}, en};

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - 32-iteration signed shift-add multiply / restoring divide unit
module multdiv_unit
   import multdiv_unit_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   state_t             state;
   op_t                op;
   op_t                start_op;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] div_shift;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_diff;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH-1:0]   fix_res;
   logic [WIDTH-1:0]   fin_res;
   logic               fin_exc;
   logic               mult_ovf;
   logic               res_neg;
   logic               div_err;
   logic               start;

   multdiv_unit_twos_negate u_abs_a (
      .en (data_operandA[WIDTH-1]),
      .a  (data_operandA),
      .y  (abs_a)
   );

   multdiv_unit_twos_negate u_abs_b (
      .en (data_operandB[WIDTH-1]),
      .a  (data_operandB),
      .y  (abs_b)
   );

   assign start    = (ctrl_MULT | ctrl_DIV) && (state != ST_RUN);
   assign start_op = ctrl_MULT ? OP_MULT : OP_DIV;

   // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
   always_comb begin
      add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      div_shift = {acc[2*WIDTH-2:0], 1'b0};
      sub_diff  = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, opnd};
      acc_next  = acc;
      if (op == OP_MULT) begin
         if (acc[0]) acc_next = {add_sum, acc[WIDTH-1:1]};
         else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end else begin
         if (!sub_diff[WIDTH]) acc_next = {sub_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
         else                  acc_next = div_shift;
      end
   end

   multdiv_unit_twos_negate u_fix (
      .en (res_neg),
      .a  (acc_next[WIDTH-1:0]),
      .y  (fix_res)
   );

   // A negative result may reach magnitude 2^31; a positive one must stay below it
   assign mult_ovf = (acc_next[2*WIDTH-1:WIDTH] != '0) ||
                     (acc_next[WIDTH-1] && (!res_neg || (acc_next[WIDTH-2:0] != '0)));
   assign fin_exc  = (op == OP_MULT) ? mult_ovf : div_err;
   assign fin_res  = ((op == OP_DIV) && div_err) ? '0 : fix_res;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         op             <= OP_MULT;
         count          <= '0;
         acc            <= '0;
         opnd           <= '0;
         res_neg        <= 1'b0;
         div_err        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            ST_RUN: begin
               acc   <= acc_next;
               count <= count + CNT_W'(1);
               if (count == CNT_W'(ITERS-1)) begin
                  state          <= ST_DONE;
                  busy           <= 1'b0;
                  data_resultRDY <= 1'b1;
                  data_result    <= fin_res;
                  data_exception <= fin_exc;
               end
            end
            default: begin
               if (start) begin
                  state   <= ST_RUN;
                  busy    <= 1'b1;
                  count   <= '0;
                  op      <= start_op;
                  res_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                  div_err <= (data_operandB == '0) ||
                             ((data_operandA == INT_MIN) && (data_operandB == NEG_ONE));
                  if (start_op == OP_MULT) begin
                     opnd <= abs_a;
                     acc  <= {{WIDTH{1'b0}}, abs_b};
                  end else begin
                     opnd <= abs_b;
                     acc  <= {{WIDTH{1'b0}}, abs_a};
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - scoreboard bench for multdiv_unit against an arithmetic reference model
module tb_multdiv_unit;

   logic        clock;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   prev_rdy = 0;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(bit is_mult, logic [31:0] a, logic [31:0] b, int ecyc);
      exp_t   r;
      longint p;
      int     qt;
      r.cyc = ecyc;
      if (is_mult) begin
         p     = longint'($signed(a)) * longint'($signed(b));
         r.res = p[31:0];
         r.exc = (p != longint'($signed(p[31:0])));
      end else if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
         r.res = 0;
         r.exc = 1;
      end else begin
         qt    = $signed(a) / $signed(b);
         r.res = qt;
         r.exc = 0;
      end
      return r;
   endfunction

   // Monitor: busy window and completion contents are judged from the scoreboard alone
   always @(negedge clock) begin
      if (!reset) begin
         if (q.size() > 0)
            check("busy", {31'b0, busy},
                  {31'b0, (cyc >= q[0].cyc - 32) && (cyc < q[0].cyc)});
         else
            check("busy_idle", {31'b0, busy}, 32'd0);
         if (data_resultRDY) begin
            check("rdy_single_pulse", {31'b0, prev_rdy}, 32'd0);
            if (q.size() == 0) begin
               check("rdy_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("result", data_result, e.res);
               check("exception", {31'b0, data_exception}, {31'b0, e.exc});
               check("rdy_cycle", cyc, e.cyc);
            end
         end
         prev_rdy = data_resultRDY;
      end else begin
         prev_rdy = 0;
      end
   end

   task automatic start_op(bit m, bit d, logic [31:0] a, logic [31:0] b);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      q.push_back(model(m, a, b, cyc + 33));
      @(negedge clock);
      ctrl_MULT     = 0;
      ctrl_DIV      = 0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic wait_rdy();
      for (int i = 0; i < 40; i++) begin
         if (data_resultRDY) return;
         @(negedge clock);
      end
      n_checks++;
      n_fail++;
      $display("FAIL rdy_timeout: actual no pulse in 40 cycles required pulse");
      q.delete();
   endtask

   task automatic do_op(bit m, bit d, logic [31:0] a, logic [31:0] b);
      start_op(m, d, a, b);
      wait_rdy();
      @(negedge clock);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'd0;
         3: return $urandom_range(0, 200) - 100;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset         = 1;
      ctrl_MULT     = 0;
      ctrl_DIV      = 0;
      data_operandA = 0;
      data_operandB = 0;
      repeat (2) @(negedge clock);
      check("reset_result", data_result, 32'd0);
      check("reset_exception", {31'b0, data_exception}, 32'd0);
      check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      reset = 0;
      @(negedge clock);

      do_op(1, 0, 32'd6, 32'd7);
      do_op(1, 0, -32'sd3, 32'd5);
      do_op(1, 0, 32'h0001_0000, 32'h0001_0000);
      do_op(1, 0, 32'h8000_0000, 32'd1);
      do_op(0, 1, -32'sd7, 32'd2);
      do_op(0, 1, 32'd100, 32'd7);
      do_op(0, 1, 32'd7, -32'sd7);
      do_op(0, 1, 32'd5, 32'd0);
      do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);

      start_op(0, 1, 32'd100, 32'd7);
      repeat (9) @(negedge clock);
      data_operandA = 32'd3;
      data_operandB = 32'd5;
      ctrl_MULT     = 1;
      @(negedge clock);
      ctrl_MULT     = 0;
      wait_rdy();
      @(negedge clock);

      do_op(1, 1, 32'd3, 32'd4);

      start_op(1, 0, 32'd11, 32'd13);
      wait_rdy();
      start_op(0, 1, -32'sd1000, 32'd9);
      wait_rdy();
      @(negedge clock);

      start_op(1, 0, 32'd123, 32'd456);
      repeat (9) @(negedge clock);
      #2 reset = 1;
      #1;
      check("async_reset_result", data_result, 32'd0);
      check("async_reset_exception", {31'b0, data_exception}, 32'd0);
      check("async_reset_rdy", {31'b0, data_resultRDY}, 32'd0);
      check("async_reset_busy", {31'b0, busy}, 32'd0);
      q.delete();
      @(negedge clock);
      #2 reset = 0;
      repeat (40) @(negedge clock);
      do_op(1, 0, 32'd2, 32'd2);

      for (int i = 0; i < 40; i++) begin
         bit m;
         m = $urandom_range(0, 1) == 1;
         start_op(m, !m, rand_operand(), rand_operand());
         wait_rdy();
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      @(negedge clock);

      check("scoreboard_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
